// File: rtl/down_scale_2x2_if.sv
// rtl/down_scale_2x2_if.sv - pixel stream input and Down_FIFO write-side bundle
interface down_scale_2x2_if;
  logic        in_vs;
  logic        in_de;
  logic [23:0] in_data;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [23:0] fifo_wr_data;

  // Source of pixels and owner of the FIFO status
  modport master (
    output in_vs, in_de, in_data, fifo_full,
    input  fifo_wr_en, fifo_wr_data
  );

  // The downscaler itself
  modport slave (
    input  in_vs, in_de, in_data, fifo_full,
    output fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/down_scale_2x2.sv
// rtl/down_scale_2x2.sv - 2x2 block-averaging RGB888 downscaler feeding Down_FIFO
module down_scale_2x2 #(
  parameter int H_ACT_MAX = 1280,
  parameter int DROP_W    = 16,
  parameter bit ROUND     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  down_scale_2x2_if.slave   vif,
  output logic              frame_start,
  output logic              ovf_flag,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int DEPTH  = H_ACT_MAX / 2;
  localparam int COL_W  = $clog2(H_ACT_MAX + 1);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [9:0] RND = ROUND ? 10'd2 : 10'd0;

  typedef enum logic {WAIT_VS = 1'b0, ACTIVE = 1'b1} state_t;

  state_t            state_q;
  state_t            state_d;
  logic              active;

  logic              vs_d;
  logic              de_d;
  logic              vs_rise;
  logic              de_fall;

  logic [COL_W-1:0]  col;
  logic              row_odd;
  logic [23:0]       held;
  logic [26:0]       hsum;
  logic              pix_ok;
  logic              pair;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] addr;

  logic [26:0]       linebuf [DEPTH];
  logic [26:0]       rd_q;
  logic [26:0]       s1_hsum;
  logic              s1_vld;
  logic [23:0]       avg;

  assign vs_rise = vif.in_vs & ~vs_d;
  assign de_fall = de_d & ~vif.in_de;

  // A vsync edge always wins: the pixel presented in that cycle belongs to no frame
  assign pix_ok = active & vif.in_de & ~vs_rise & (col < COL_W'(H_ACT_MAX));
  assign pair   = pix_ok & col[0];
  assign addr   = ADDR_W'(col >> 1);
  // Even rows only write the line buffer, odd rows only read it: one port suffices
  assign mem_we = pair & ~row_odd;
  assign mem_re = pair & row_odd;

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_VS;
    else        state_q <= state_d;
  end

  // Next state: the first vsync edge arms the block; only reset disarms it
  always_comb begin
    state_d = state_q;
    if (vs_rise) state_d = ACTIVE;
  end

  // FSM output: pixels are only accepted once a frame has started
  always_comb begin
    active = (state_q == ACTIVE);
  end

  // Previous-cycle copies of vsync and data-enable for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= 1'b0;
      de_d <= 1'b0;
    end else begin
      vs_d <= vif.in_vs;
      de_d <= vif.in_de;
    end
  end

  // Column counter (stops at H_ACT_MAX) and row parity, both restarted by vsync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row_odd <= 1'b0;
    end else if (vs_rise) begin
      col     <= '0;
      row_odd <= 1'b0;
    end else if (active) begin
      if (de_fall) begin
        col     <= '0;
        row_odd <= ~row_odd;
      end else if (pix_ok) begin
        col <= col + 1'b1;
      end
    end
  end

  // Hold the even-column pixel until its odd-column partner arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   held <= '0;
    else if (vs_rise)             held <= '0;
    else if (pix_ok && !col[0])   held <= vif.in_data;
  end

  // Horizontal pair sum, 9 bits per channel
  always_comb begin
    hsum = '0;
    for (int c = 0; c < 3; c++) begin
      hsum[c*9 +: 9] = {1'b0, held[c*8 +: 8]} + {1'b0, vif.in_data[c*8 +: 8]};
    end
  end

  // Single-port line buffer: even-row pair sums in, read back on the odd row
  always_ff @(posedge clk) begin
    if (mem_we)      linebuf[addr] <= hsum;
    else if (mem_re) rd_q          <= linebuf[addr];
  end

  // Align the odd-row pair sum with the line buffer read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_hsum <= '0;
    end else begin
      s1_vld <= mem_re;
      if (mem_re) s1_hsum <= hsum;
    end
  end

  // Four-pixel average per channel; 1020 + 2 still fits in 10 bits
  always_comb begin
    avg = '0;
    for (int c = 0; c < 3; c++) begin
      avg[c*8 +: 8] = 8'(({1'b0, rd_q[c*9 +: 9]} + {1'b0, s1_hsum[c*9 +: 9]} + RND) >> 2);
    end
  end

  // FIFO write or drop (full is sampled the cycle before the strobe would show)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vif.fifo_wr_en   <= 1'b0;
      vif.fifo_wr_data <= '0;
      drop_cnt         <= '0;
      ovf_flag         <= 1'b0;
      frame_start      <= 1'b0;
    end else begin
      frame_start    <= vs_rise;
      vif.fifo_wr_en <= 1'b0;
      if (vs_rise) begin
        drop_cnt <= '0;
        ovf_flag <= 1'b0;
      end else if (s1_vld) begin
        if (vif.fifo_full) begin
          if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
          ovf_flag <= 1'b1;
        end else begin
          vif.fifo_wr_en   <= 1'b1;
          vif.fifo_wr_data <= avg;
        end
      end
    end
  end

endmodule
